// File: rtl/priority_enc_pkg.sv
// rtl/priority_enc_pkg.sv - shared types, widths and bit-vector helpers for the scanning priority encoder
package priority_enc_pkg;

    localparam int VEC_W = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Number of set bits; CNT_W is wide enough to hold VEC_W without wrapping
    function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < VEC_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // True for an all-zero or one-hot vector
    function automatic logic at_most_one(input logic [VEC_W-1:0] v);
        return ((v & (v - VEC_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/priority_encoder_8to3.sv
// rtl/priority_encoder_8to3.sv - combinational highest-set-bit encoder with any-bit flag
module priority_encoder_8to3
    import priority_enc_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan upward so the highest set bit is the last one to win
    always_comb begin
        idx = '0;
        for (int i = 0; i < VEC_W; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/priority_encoder_8to3_scan.sv
// rtl/priority_encoder_8to3_scan.sv - captures a request vector and streams its set indices high to low
module priority_encoder_8to3_scan
    import priority_enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [VEC_W-1:0] in,
    output logic             in_ready,
    output logic [IDX_W-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             last,
    output logic             zero,
    output logic [CNT_W-1:0] count
);

    state_t           state;
    logic [VEC_W-1:0] pending;
    logic [VEC_W-1:0] next_vec;
    logic [IDX_W-1:0] next_idx;
    logic             next_any;
    logic             accept;
    logic             beat_done;

    assign in_ready  = (state == IDLE) && en;
    assign accept    = in_valid && in_ready;
    assign beat_done = out_valid && out_ready;

    // Vector the next presented beat is drawn from: the incoming vector while idle,
    // otherwise pending with the currently presented bit removed
    always_comb begin
        next_vec = '0;
        if (state == IDLE) begin
            next_vec = in;
        end else begin
            next_vec = pending & ~(VEC_W'(1) << out);
        end
    end

    priority_encoder_8to3 u_enc (
        .vec (next_vec),
        .idx (next_idx),
        .any (next_any)
    );

    // State, pending bits and all registered outputs; a beat only advances on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            last      <= 1'b0;
            zero      <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= EMIT;
                        pending   <= in;
                        out       <= next_idx;
                        out_valid <= 1'b1;
                        last      <= at_most_one(in);
                        zero      <= !next_any;
                        count     <= popcount(in);
                    end
                end
                EMIT: begin
                    if (beat_done) begin
                        if (last) begin
                            state     <= IDLE;
                            pending   <= '0;
                            out       <= '0;
                            out_valid <= 1'b0;
                            last      <= 1'b0;
                            zero      <= 1'b0;
                            count     <= '0;
                        end else begin
                            pending <= next_vec;
                            out     <= next_idx;
                            last    <= at_most_one(next_vec);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
